// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths and FSM state encoding for the instruction fetch controller.
package ifetch_pkg;
    localparam int INSTR_W = 17;
    localparam int ADDR_W  = 12;
    localparam int ENTRY_W = INSTR_W + ADDR_W;
    typedef enum logic [1:0] {FETCH, FULL, HALT, FAULT} state_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: prefetch FIFO with independent read/write pointers, synchronous flush
// and a zeroed head while empty.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // A push into a full FIFO lands on the slot being popped at the same edge.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencing and prefetch into a FIFO with halt/redirect control.
// Define IFETCH_BOUND_CHECK_EN to trap fetches at or beyond ROM_WORDS into a sticky fault.
module instr_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                ROM_WORDS = 512,
    parameter logic [ADDR_W-1:0] RESET_PC  = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault
);
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_ctrl: DEPTH must be a power of two in 2..16");
    end
    if (ROM_WORDS < 1 || ROM_WORDS > 4096) begin : g_bad_rom
        $error("instr_fetch_ctrl: ROM_WORDS must be in 1..4096");
    end

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                r_fault;
    logic                w_fault_next;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_full;
    logic                w_oob;
    logic                w_tgt_oob;
    logic [ENTRY_W-1:0]  w_head;

`ifdef IFETCH_BOUND_CHECK_EN
    assign w_oob     = int'({20'b0, r_pc}) >= ROM_WORDS;
    assign w_tgt_oob = int'({20'b0, redirect_pc}) >= ROM_WORDS;
`else
    assign w_oob     = 1'b0;
    assign w_tgt_oob = 1'b0;
`endif

    assign imem_addr = r_pc;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign out_pc    = w_head[ENTRY_W-1:INSTR_W];
    assign out_instr = w_head[INSTR_W-1:0];
    assign fault     = r_fault;

    always_comb begin
        w_next       = r_state;
        w_pc_next    = r_pc;
        w_fault_next = r_fault;
        w_push       = 1'b0;
        if (redirect_valid) begin
            w_next       = halt ? HALT : FETCH;
            w_pc_next    = redirect_pc;
            w_fault_next = r_fault && w_tgt_oob;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (halt) begin
                        w_next = HALT;
                    end else if (w_oob) begin
                        w_next       = FAULT;
                        w_fault_next = 1'b1;
                    end else if (w_full && !w_pop) begin
                        w_next = FULL;
                    end else begin
                        w_push    = 1'b1;
                        w_pc_next = r_pc + 1'b1;
                    end
                end
                FULL:    w_next = halt ? HALT : (w_pop ? FETCH : FULL);
                HALT:    w_next = halt ? HALT : FETCH;
                default: w_next = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            r_fault <= w_fault_next;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_pc, imem_rd}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios with an expected-PC scoreboard checked at each handshake.
module tb_instr_fetch_ctrl;
    import ifetch_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rd;
    logic               halt;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               fault;

    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return 17'h1A001 + {5'b0, a};
    endfunction

    assign imem_rd = rom(imem_addr);

    instr_fetch_ctrl #(.DEPTH(4), .ROM_WORDS(512), .RESET_PC(12'h000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Score the head if it is handshaken at the coming edge, then advance one cycle.
    task automatic tick();
        logic [ADDR_W-1:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_pop: observed pc %0h expected none", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", 32'(out_pc), 32'(e));
                check("pop_instr", 32'(out_instr), 32'(rom(e)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_pc", 32'(out_pc), 0);
        check("rst_instr", 32'(out_instr), 0);
        check("rst_fault", 32'(fault), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        check("rel_valid", 32'(out_valid), 0);
        exp_q.push_back(12'h000); exp_q.push_back(12'h001); exp_q.push_back(12'h002);
        tick();
        check("lat_valid", 32'(out_valid), 1);
        check("lat_pc", 32'(out_pc), 0);
        tick(); tick(); tick();
        out_ready = 1'b0;
        check("stream_drained", 32'(exp_q.size()), 0);

        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("full_head_pc", 32'(out_pc), 0);
        end
        check("full_count", 32'(dut.u_fifo.r_count), 4);
        check("full_addr", 32'(imem_addr), 4);
        check("full_state", 32'(dut.r_state), 32'(FULL));
        check("full_head_instr", 32'(out_instr), 32'h1A001);

        reset = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 0);
        check("async_addr", 32'(imem_addr), 0);
        check("async_pc", 32'(out_pc), 0);
        check("async_instr", 32'(out_instr), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        tick(); tick(); tick();
        check("pre_redir_count", 32'(dut.u_fifo.r_count), 3);
        redirect_valid = 1'b1; redirect_pc = 12'h080;
        tick();
        redirect_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 0);
        check("flush_count", 32'(dut.u_fifo.r_count), 0);
        check("redir_addr", 32'(imem_addr), 32'h080);
        exp_q.push_back(12'h080); exp_q.push_back(12'h081);
        out_ready = 1'b1;
        tick();
        check("redir_head", 32'(out_pc), 32'h080);
        tick(); tick();
        out_ready = 1'b0;

        tick();
        check("pre_halt_count", 32'(dut.u_fifo.r_count), 2);
        halt = 1'b1; out_ready = 1'b1;
        exp_q.push_back(12'h082); exp_q.push_back(12'h083);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_addr", 32'(imem_addr), 32'h084);
        end
        check("halt_drained", 32'(out_valid), 0);
        check("halt_state", 32'(dut.r_state), 32'(HALT));
        halt = 1'b0;
        exp_q.push_back(12'h084); exp_q.push_back(12'h085);
        tick();
        check("resume_addr", 32'(imem_addr), 32'h084);
        tick(); tick(); tick();
        out_ready = 1'b0;

`ifdef IFETCH_BOUND_CHECK_EN
        redirect_valid = 1'b1; redirect_pc = 12'h1FF;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(12'h1FF);
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("oob_fault", 32'(fault), 1);
        check("oob_state", 32'(dut.r_state), 32'(FAULT));
        check("oob_addr", 32'(imem_addr), 32'h200);
        check("oob_valid", 32'(out_valid), 0);
        redirect_valid = 1'b1; redirect_pc = 12'h010;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        check("oob_clear", 32'(fault), 0);
`else
        redirect_valid = 1'b1; redirect_pc = 12'hFFF;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(12'hFFF); exp_q.push_back(12'h000);
        out_ready = 1'b1;
        tick();
        check("wrap_addr", 32'(imem_addr), 0);
        tick(); tick();
        check("wrap_fault", 32'(fault), 0);
        exp_q.push_back(12'h001);
        redirect_valid = 1'b1; redirect_pc = 12'h100;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        check("pop_redir_count", 32'(dut.u_fifo.r_count), 0);
        check("pop_redir_addr", 32'(imem_addr), 32'h100);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ROM_WORDS, default 512, populated instruction-memory words.
REQ-003 SHALL have parameter RESET_PC, default 12'h000, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_addr  output  12  word address driven to instruction memory.
REQ-007 SHALL have port imem_rd  input  17  combinational read data of imem_addr, same cycle.
REQ-008 SHALL have port halt  input  1  suppresses new fetches while high.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump request.
REQ-010 SHALL have port redirect_pc  input  12  redirect target.
REQ-011 SHALL have port out_valid  output  1  FIFO head holds an instruction.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have port out_instr  output  17  head instruction.
REQ-014 SHALL have port out_pc  output  12  head instruction address.
REQ-015 SHALL have port fault  output  1  out-of-range fetch flag (REQ-033 only; tied 0 otherwise).

Function
REQ-016 SHALL drive imem_addr = PC register continuously.
REQ-017 SHALL implement FSM states FETCH, FULL, HALT, FAULT.
REQ-018 SHALL, in FETCH, enqueue {PC, imem_rd} and set PC = PC+1 each edge where push is allowed.
REQ-019 SHALL allow push when count < DEPTH, or count == DEPTH with a pop in the same cycle.
REQ-020 SHALL enter FULL when count == DEPTH and no pop; return to FETCH on first pop.
REQ-021 SHALL enter HALT when halt=1 (no push, PC held); return to FETCH when halt=0.
REQ-022 SHALL keep draining FIFO in FULL, HALT and FAULT.
REQ-023 SHALL complete a pop when out_valid && out_ready; out_instr/out_pc stable while out_valid && !out_ready.
REQ-024 SHALL assert out_valid the cycle after the edge that enqueued into an empty FIFO (one-cycle fetch-to-output latency).
REQ-025 SHALL give redirect_valid priority over halt, push and state: flush FIFO, PC = redirect_pc, no push that cycle, next state FETCH (or HALT if halt=1).
REQ-026 SHALL count a pop coinciding with redirect as delivered; the flush discards all remaining entries.
REQ-027 SHALL wrap PC 12'hFFF -> 12'h000 modulo 2^12.
REQ-028 SHALL keep pop and push independent pointers; simultaneous push+pop leaves count unchanged.

Reset
REQ-029 SHALL, on reset low, asynchronously set PC=RESET_PC, state FETCH, FIFO empty, out_valid=0, fault=0.
REQ-030 SHALL hold out_instr=17'h0 and out_pc=12'h0 while empty and in reset.
REQ-031 SHALL discard all in-flight entries on reset mid-operation; first enqueue occurs at the first edge after release.

Configuration
REQ-032 SHALL compile bounds checking only when macro IFETCH_BOUND_CHECK_EN is defined.
REQ-033 SHALL, with IFETCH_BOUND_CHECK_EN, enter FAULT instead of pushing when PC >= ROM_WORDS, set fault=1 (sticky), hold PC; leave only via redirect (in-range target) or reset.
REQ-034 SHALL, without IFETCH_BOUND_CHECK_EN, never enter FAULT, tie fault=0 and fetch any address.

Structure
REQ-035 SHALL place INSTR_W=17, ADDR_W=12 and the FSM state enum in package ifetch_pkg.
REQ-036 SHALL implement the FIFO as sub-module ifetch_fifo (parameterised DEPTH, width INSTR_W+ADDR_W, flush input).

Verification
REQ-037 SHALL verify reset release, out_ready=1, ROM[0..2]=1A001,1A002,1A003 -> out_valid at 2nd edge, out_pc 0,1,2 consecutive cycles.
REQ-038 SHALL verify out_ready=0 for 10 cycles, DEPTH=4 -> 4 entries (pc 0..3), PC=4, state FULL, head stable.
REQ-039 SHALL verify redirect_valid with redirect_pc=12'h080 while 3 entries queued -> FIFO empty next cycle, next output out_pc=080.
REQ-040 SHALL verify halt=1 for 5 cycles -> no push, queued entries drain, PC unchanged; halt=0 resumes at held PC.
REQ-041 SHALL verify redirect_pc=12'hFFF -> outputs FFF then 000 (macro undefined); with IFETCH_BOUND_CHECK_EN, redirect_pc=12'h1FF -> output 1FF, then fault=1, no 200 entry.
REQ-042 SHALL verify reset asserted with FIFO full -> out_valid=0 and PC=RESET_PC immediately, without clock edge.
